cb_trigger_scheduler: RTL and testbench

//  Shares the single circuit-breaker trigger input between N_SRC anomaly sources (ML, cascade, rule->ML).

---
 rtl/nanotrade_cb_pkg.sv | 31 +++
 rtl/cb_src_slot.sv | 50 +++++
 rtl/cb_trigger_scheduler.sv | 176 +++++++++++++++++
 tb/tb_cb_trigger_scheduler.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nanotrade_cb_pkg.sv
// Shared encodings for the circuit-breaker trigger scheduler.
package nanotrade_cb_pkg;

  localparam logic [2:0] C_NORMAL = 3'd0;
  localparam logic [2:0] C_FLASH  = 3'd3;
  localparam logic [2:0] C_IMB    = 3'd4;
  localparam logic [2:0] C_STUFF  = 3'd5;

  localparam logic [1:0] CB_NORMAL   = 2'b00;
  localparam logic [1:0] CB_THROTTLE = 2'b01;
  localparam logic [1:0] CB_WIDEN    = 2'b10;
  localparam logic [1:0] CB_PAUSE    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_ACTIVE   = 3'd3,
    S_HOLDOFF  = 3'd4
  } sched_state_t;

  function automatic logic [1:0] severity(input logic [2:0] cls);
    case (cls)
      C_FLASH: severity = 2'd3;
      C_IMB:   severity = 2'd2;
      C_STUFF: severity = 2'd1;
      default: severity = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/cb_src_slot.sv
// One pending-trigger slot: intake, clear on grant, stale drop.
module cb_src_slot
  import nanotrade_cb_pkg::*;
#(
  parameter int CONF_BITS = 8,
  parameter int MAX_AGE   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [2:0]           in_class,
  input  logic [CONF_BITS-1:0] in_conf,
  input  logic                 grant,
  output logic                 full,
  output logic [2:0]           cls,
  output logic [CONF_BITS-1:0] conf,
  output logic                 drop_pulse
);

  localparam int AW = $clog2(MAX_AGE + 1);

  logic [AW-1:0] age;
  logic          accept;

  // Non-triggering classes complete the handshake but are never stored.
  assign accept     = in_valid && !full && (severity(in_class) != 2'd0);
  assign drop_pulse = full && !grant && (age == AW'(MAX_AGE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      cls  <= '0;
      conf <= '0;
      age  <= '0;
    end else if (accept) begin
      full <= 1'b1;
      cls  <= in_class;
      conf <= in_conf;
      age  <= '0;
    end else if (full) begin
      if (grant || drop_pulse) begin
        full <= 1'b0;
        age  <= '0;
      end else begin
        age <= age + AW'(1);
      end
    end
  end

endmodule

// File: rtl/cb_trigger_scheduler.sv
// Arbitrates buffered anomaly triggers onto the single breaker trigger input.
module cb_trigger_scheduler
  import nanotrade_cb_pkg::*;
#(
  parameter int N_SRC     = 3,
  parameter int CONF_BITS = 8,
  parameter int MAX_AGE   = 255,
  parameter int ACK_TMO   = 4,
  parameter int HOLDOFF   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_SRC-1:0]               src_valid,
  input  logic [3*N_SRC-1:0]             src_class,
  input  logic [CONF_BITS*N_SRC-1:0]     src_conf,
  output logic [N_SRC-1:0]               src_ready,
  input  logic [1:0]                     cb_state,
  input  logic                           cb_active,
  output logic                           trig_valid,
  output logic [2:0]                     trig_class,
  output logic [CONF_BITS-1:0]           trig_conf,
  output logic [2:0]                     grant_src,
  output logic [2:0]                     sched_state,
  output logic [7:0]                     drop_cnt,
  output logic [7:0]                     tmo_cnt
);

  localparam int IW   = $clog2(N_SRC);
  localparam int TW_A = $clog2(ACK_TMO);
  localparam int TW_H = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam int TW   = (TW_A > TW_H) ? TW_A : TW_H;

  logic [N_SRC-1:0]     slot_full, slot_grant, slot_drop;
  logic [2:0]           slot_cls  [N_SRC];
  logic [CONF_BITS-1:0] slot_conf [N_SRC];

  logic [IW-1:0]        rr_ptr, best_idx, idx;
  logic [IW:0]          sum;
  logic [CONF_BITS+1:0] best_key, key;
  logic                 best_found, any_full, issue_go, tmo_hit;
  logic [8:0]           drop_acc;
  logic [7:0]           drop_next;

  sched_state_t  state, state_nxt;
  logic [TW-1:0] tmr, tmr_nxt;

  assign src_ready   = ~slot_full;
  assign any_full    = |slot_full;
  assign sched_state = state;

  for (genvar i = 0; i < N_SRC; i++) begin : g_slot
    assign slot_grant[i] = issue_go && (best_idx == IW'(i));

    cb_src_slot #(
      .CONF_BITS(CONF_BITS),
      .MAX_AGE  (MAX_AGE)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (src_valid[i]),
      .in_class  (src_class[3*i +: 3]),
      .in_conf   (src_conf[CONF_BITS*i +: CONF_BITS]),
      .grant     (slot_grant[i]),
      .full      (slot_full[i]),
      .cls       (slot_cls[i]),
      .conf      (slot_conf[i]),
      .drop_pulse(slot_drop[i])
    );
  end

  // Scan starts at rr_ptr with a strict compare, so full ties resolve round-robin.
  always_comb begin
    best_found = 1'b0;
    best_idx   = '0;
    best_key   = '0;
    sum        = '0;
    idx        = '0;
    key        = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      sum = {1'b0, rr_ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N_SRC)) sum = sum - (IW+1)'(N_SRC);
      idx = sum[IW-1:0];
      key = {severity(slot_cls[idx]), slot_conf[idx]};
      if (slot_full[idx] && (!best_found || key > best_key)) begin
        best_found = 1'b1;
        best_idx   = idx;
        best_key   = key;
      end
    end
  end

  always_comb begin
    drop_acc = {1'b0, drop_cnt};
    for (int unsigned k = 0; k < N_SRC; k++) begin
      drop_acc = drop_acc + 9'(slot_drop[k]);
    end
    drop_next = (drop_acc > 9'd255) ? 8'hFF : drop_acc[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      tmr   <= '0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    issue_go  = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_full && cb_state == CB_NORMAL && !cb_active) begin
          issue_go  = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_nxt = S_WAIT_ACK;
        tmr_nxt   = '0;
      end
      S_WAIT_ACK: begin
        if (cb_active) begin
          state_nxt = S_ACTIVE;
        end else if (tmr == TW'(ACK_TMO - 1)) begin
          tmo_hit   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          tmr_nxt = tmr + TW'(1);
        end
      end
      S_ACTIVE: begin
        if (!cb_active) begin
          if (HOLDOFF == 0) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_HOLDOFF;
            tmr_nxt   = '0;
          end
        end
      end
      S_HOLDOFF: begin
        if (tmr == TW'(HOLDOFF - 1)) state_nxt = S_IDLE;
        else                         tmr_nxt   = tmr + TW'(1);
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_valid <= 1'b0;
      trig_class <= '0;
      trig_conf  <= '0;
      grant_src  <= '0;
      rr_ptr     <= '0;
      drop_cnt   <= '0;
      tmo_cnt    <= '0;
    end else begin
      trig_valid <= issue_go;
      drop_cnt   <= drop_next;
      if (tmo_hit && tmo_cnt != 8'hFF) tmo_cnt <= tmo_cnt + 8'd1;
      if (issue_go) begin
        trig_class <= slot_cls[best_idx];
        trig_conf  <= slot_conf[best_idx];
        grant_src  <= 3'(best_idx);
        rr_ptr     <= (best_idx == IW'(N_SRC - 1)) ? '0 : best_idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_cb_trigger_scheduler.sv
// Directed scoreboard bench for cb_trigger_scheduler.
module tb_cb_trigger_scheduler;
  import nanotrade_cb_pkg::*;

  localparam int N_SRC     = 3;
  localparam int CONF_BITS = 8;
  localparam int MAX_AGE   = 255;
  localparam int ACK_TMO   = 4;
  localparam int HOLDOFF   = 16;
  localparam int ACT_LEN   = 6;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic [N_SRC-1:0]           src_valid = '0;
  logic [3*N_SRC-1:0]         src_class = '0;
  logic [CONF_BITS*N_SRC-1:0] src_conf  = '0;
  logic [N_SRC-1:0]           src_ready;
  logic [1:0]                 cb_state  = CB_NORMAL;
  logic                       cb_active;
  logic                       trig_valid;
  logic [2:0]                 trig_class;
  logic [CONF_BITS-1:0]       trig_conf;
  logic [2:0]                 grant_src;
  logic [2:0]                 sched_state;
  logic [7:0]                 drop_cnt;
  logic [7:0]                 tmo_cnt;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [2:0] cls;
    logic [7:0] conf;
    logic [2:0] src;
    bit         gap;
  } exp_t;
  exp_t exp_q[$];

  // Simple breaker model: acknowledges a pulse with ACT_LEN cycles of cb_active.
  bit brk_ack   = 1'b1;
  bit force_en  = 1'b0;
  bit force_val = 1'b0;
  int auto_cnt  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (trig_valid && brk_ack) auto_cnt <= ACT_LEN;
    else if (auto_cnt != 0)    auto_cnt <= auto_cnt - 1;
  end

  assign cb_active = force_en ? force_val : (auto_cnt != 0);

  cb_trigger_scheduler #(
    .N_SRC    (N_SRC),
    .CONF_BITS(CONF_BITS),
    .MAX_AGE  (MAX_AGE),
    .ACK_TMO  (ACK_TMO),
    .HOLDOFF  (HOLDOFF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .src_valid  (src_valid),
    .src_class  (src_class),
    .src_conf   (src_conf),
    .src_ready  (src_ready),
    .cb_state   (cb_state),
    .cb_active  (cb_active),
    .trig_valid (trig_valid),
    .trig_class (trig_class),
    .trig_conf  (trig_conf),
    .grant_src  (grant_src),
    .sched_state(sched_state),
    .drop_cnt   (drop_cnt),
    .tmo_cnt    (tmo_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic [2:0] c, input logic [7:0] f);
    src_class[3*s +: 3] = c;
    src_conf[8*s +: 8]  = f;
    src_valid[s]        = 1'b1;
  endtask

  task automatic expect_issue(input logic [2:0] c, input logic [7:0] f,
                              input logic [2:0] s, input bit g);
    exp_t e;
    e.cls  = c;
    e.conf = f;
    e.src  = s;
    e.gap  = g;
    exp_q.push_back(e);
  endtask

  task automatic wait_state(input string name, input logic [2:0] s, input int max);
    for (int i = 0; i < max && sched_state != s; i++) tick(1);
    check(name, 32'(sched_state), 32'(s));
  endtask

  task automatic wait_drain(input string name, input int max);
    for (int i = 0; i < max; i++) begin
      if (exp_q.size() == 0 && sched_state == S_IDLE && !cb_active) break;
      tick(1);
    end
    check(name, 32'(exp_q.size() == 0 && sched_state == S_IDLE && !cb_active), 1);
  endtask

  // Monitor: pops the scoreboard on every issue pulse.
  int since   = 0;
  bit prev_act = 1'b0;
  bit prev_tv  = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_act = 1'b0;
        prev_tv  = 1'b0;
        since    = 0;
      end else begin
        if (prev_act && !cb_active) since = 0;
        else                        since++;
        prev_act = cb_active;
        if (trig_valid) begin
          check("pulse_width", 32'(prev_tv), 0);
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", 32'(trig_valid), 0);
          end else begin
            e = exp_q.pop_front();
            check("issue_class", 32'(trig_class), 32'(e.cls));
            check("issue_conf",  32'(trig_conf),  32'(e.conf));
            check("issue_src",   32'(grant_src),  32'(e.src));
            if (e.gap) check("holdoff_gap", since, HOLDOFF + 2);
          end
        end
        prev_tv = trig_valid;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n0, n2, guard;

    // Reset state
    tick(2);
    check("rst_trig_valid", 32'(trig_valid), 0);
    check("rst_trig_class", 32'(trig_class), 0);
    check("rst_trig_conf",  32'(trig_conf), 0);
    check("rst_grant_src",  32'(grant_src), 0);
    check("rst_drop_cnt",   32'(drop_cnt), 0);
    check("rst_tmo_cnt",    32'(tmo_cnt), 0);
    check("rst_src_ready",  32'(src_ready), 32'h7);
    check("rst_state",      32'(sched_state), 32'(S_IDLE));
    rst = 1'b0;
    tick(2);

    // 1: single STUFF on src0
    set_src(0, C_STUFF, 8'd60);
    expect_issue(C_STUFF, 8'd60, 3'd0, 1'b0);
    tick(1);
    src_valid = '0;
    check("t1_ready_low_after_store", 32'(src_ready[0]), 0);
    tick(1);
    check("t1_pulse_latency", 32'(trig_valid), 1);
    check("t1_ready_back", 32'(src_ready[0]), 1);
    check("t1_state_issue", 32'(sched_state), 32'(S_ISSUE));
    wait_drain("t1_drain", 200);

    // 4: breaker paused and active; pending FLASH goes stale
    cb_state  = CB_PAUSE;
    force_val = 1'b1;
    force_en  = 1'b1;
    tick(1);
    set_src(1, C_FLASH, 8'd77);
    tick(1);
    src_valid = '0;
    tick(255);
    check("t4_drop_before_age", 32'(drop_cnt), 0);
    check("t4_slot_still_full", 32'(src_ready[1]), 0);
    tick(1);
    check("t4_drop_at_age", 32'(drop_cnt), 1);
    check("t4_slot_freed", 32'(src_ready[1]), 1);
    tick(43);
    cb_state = CB_NORMAL;
    force_en = 1'b0;
    tick(10);
    check("t4_state_idle", 32'(sched_state), 32'(S_IDLE));
    check("t4_drop_final", 32'(drop_cnt), 1);

    // 5: first issue never acknowledged, second is issued right after
    brk_ack = 1'b0;
    set_src(1, C_FLASH, 8'd33);
    set_src(2, C_STUFF, 8'd44);
    expect_issue(C_FLASH, 8'd33, 3'd1, 1'b0);
    expect_issue(C_STUFF, 8'd44, 3'd2, 1'b0);
    tick(1);
    src_valid = '0;
    for (int i = 0; i < 10 && !trig_valid; i++) tick(1);
    check("t5_first_pulse", 32'(trig_valid), 1);
    tick(1);
    check("t5_wait_ack", 32'(sched_state), 32'(S_WAIT_ACK));
    tick(ACK_TMO - 1);
    check("t5_tmo_not_yet", 32'(tmo_cnt), 0);
    tick(1);
    check("t5_tmo_cnt", 32'(tmo_cnt), 1);
    check("t5_back_idle", 32'(sched_state), 32'(S_IDLE));
    brk_ack = 1'b1;
    tick(1);
    check("t5_next_issued", 32'(trig_valid), 1);
    wait_drain("t5_drain", 200);

    // 3: equal IMB/50 on src0 and src2, pointer now at 0
    for (int k = 0; k < 6; k++)
      expect_issue(C_IMB, 8'd50, (k % 2 == 0) ? 3'd0 : 3'd2, k != 0);
    n0 = 3;
    n2 = 3;
    guard = 0;
    while ((n0 > 0 || n2 > 0) && guard < 2000) begin
      src_valid = '0;
      if (n0 > 0 && src_ready[0]) begin set_src(0, C_IMB, 8'd50); n0--; end
      if (n2 > 0 && src_ready[2]) begin set_src(2, C_IMB, 8'd50); n2--; end
      tick(1);
      guard++;
    end
    src_valid = '0;
    check("t3_offers_done", n0 + n2, 0);
    wait_drain("t3_drain", 500);

    // 2: three classes offered together, issued by severity
    set_src(0, C_STUFF, 8'd200);
    set_src(1, C_FLASH, 8'd10);
    set_src(2, C_IMB,   8'd90);
    expect_issue(C_FLASH, 8'd10,  3'd1, 1'b0);
    expect_issue(C_IMB,   8'd90,  3'd2, 1'b1);
    expect_issue(C_STUFF, 8'd200, 3'd0, 1'b1);
    tick(1);
    src_valid = '0;
    wait_drain("t2_drain", 500);

    // 6: reset while ACTIVE with two slots still full
    set_src(0, C_STUFF, 8'd10);
    set_src(1, C_STUFF, 8'd20);
    set_src(2, C_STUFF, 8'd30);
    expect_issue(C_STUFF, 8'd30, 3'd2, 1'b0);
    tick(1);
    src_valid = '0;
    wait_state("t6_reach_active", S_ACTIVE, 20);
    check("t6_slots_full", 32'(src_ready), 32'h4);
    rst = 1'b1;
    #1;
    check("t6_rst_trig_valid", 32'(trig_valid), 0);
    check("t6_rst_trig_class", 32'(trig_class), 0);
    check("t6_rst_trig_conf",  32'(trig_conf), 0);
    check("t6_rst_grant_src",  32'(grant_src), 0);
    check("t6_rst_drop_cnt",   32'(drop_cnt), 0);
    check("t6_rst_tmo_cnt",    32'(tmo_cnt), 0);
    check("t6_rst_src_ready",  32'(src_ready), 32'h7);
    check("t6_rst_state",      32'(sched_state), 32'(S_IDLE));
    tick(2);
    rst = 1'b0;
    tick(1);
    set_src(0, C_NORMAL, 8'd99);
    tick(1);
    src_valid = '0;
    check("t6_class0_not_stored", 32'(src_ready[0]), 1);
    tick(30);
    check("t6_idle_after_release", 32'(sched_state), 32'(S_IDLE));
    wait_drain("final_drain", 100);
    check("leftover_expectations", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
